vga_pattern_scheduler: RTL and testbench

VGA_PATTERN_SCHEDULER -- requirements
Module: vga_pattern_scheduler

---
 rtl/vga_pattern_scheduler_if.sv | 10 +
 rtl/vga_pattern_scheduler.sv | 139 +++++++++++++
 tb/tb_vga_pattern_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_scheduler_if.sv
// Palette configuration port: write request with a ready/valid handshake.
interface vga_pattern_scheduler_if;
    logic        cfg_valid;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_ready;

    modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/vga_pattern_scheduler.sv
// Test-pattern colour scheduler: double-buffered 4-entry palette, solid or bar pattern,
// palette index stepping every FRAMES_PER_STEP frames.
//
// state | meaning
// IDLE  | stopped, rgb blanked
// ARM   | waiting for the next frame boundary, idx/fcnt held at 0
// RUN   | drawing pattern, counting frames
module vga_pattern_scheduler #(
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned H_ACTIVE        = 640
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   p_tick,
    input  logic                   video_on,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   enable,
    input  logic                   mode,
    vga_pattern_scheduler_if.slave cfg,
    output logic [11:0]            rgb,
    output logic                   step_pulse,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [10:0] BAR_W     = 11'(H_ACTIVE / 4);
    localparam logic [10:0] H_END     = 11'(H_ACTIVE);
    localparam logic [7:0]  FCNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [11:0] PAL_DEFAULT [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        dirty_q, dirty_d;
    logic [11:0] shadow_q [4];
    logic [11:0] shadow_d [4];
    logic [11:0] active_q [4];
    logic [11:0] active_d [4];
    logic [11:0] rgb_q, rgb_d;

    logic        frame_bnd;
    logic        wr_en;
    logic [10:0] x_ext;
    logic [1:0]  bar;
    logic [1:0]  sel;

    assign frame_bnd     = p_tick && (x == 10'd0) && (y == 10'd0);
    // Refusing writes on the boundary keeps the shadow stable while it is copied.
    assign cfg.cfg_ready = ~frame_bnd;
    assign wr_en         = cfg.cfg_valid && cfg.cfg_ready;
    assign x_ext         = {1'b0, x};
    assign busy          = (state_q != IDLE);
    assign rgb           = rgb_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            fcnt_q  <= 8'd0;
            dirty_q <= 1'b0;
            rgb_q   <= 12'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= PAL_DEFAULT[i];
                active_q[i] <= PAL_DEFAULT[i];
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            dirty_q  <= dirty_d;
            rgb_q    <= rgb_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        step_pulse = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (frame_bnd) state_d = RUN;
                default: state_d = state_q;
            endcase
        end

        if (state_q == ARM) begin
            idx_d  = 2'd0;
            fcnt_d = 8'd0;
        end else if (state_q == RUN && frame_bnd) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d     = 8'd0;
                idx_d      = idx_q + 2'd1;
                step_pulse = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (wr_en) begin
            shadow_d[cfg.cfg_addr] = cfg.cfg_data;
            dirty_d                = 1'b1;
        end
        if (frame_bnd && dirty_q) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
        end
    end

    always_comb begin
        if (x_ext >= H_END)
            bar = 2'd3;
        else if (x_ext >= (BAR_W << 1) + BAR_W)
            bar = 2'd3;
        else if (x_ext >= (BAR_W << 1))
            bar = 2'd2;
        else if (x_ext >= BAR_W)
            bar = 2'd1;
        else
            bar = 2'd0;

        sel   = mode ? (bar + idx_q) : idx_q;
        rgb_d = (state_q == RUN && video_on) ? active_q[sel] : 12'd0;
    end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler with FRAMES_PER_STEP=2, H_ACTIVE=640.
module tb_vga_pattern_scheduler;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic        p_tick     = 1'b0;
    logic        video_on   = 1'b0;
    logic [9:0]  x          = 10'd0;
    logic [9:0]  y          = 10'd5;
    logic        enable     = 1'b0;
    logic        mode       = 1'b0;
    logic [11:0] rgb;
    logic        step_pulse;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vga_pattern_scheduler_if cfg_if ();

    vga_pattern_scheduler #(.FRAMES_PER_STEP(2), .H_ACTIVE(640)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .enable     (enable),
        .mode       (mode),
        .cfg        (cfg_if),
        .rgb        (rgb),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py);
        p_tick = 1'b1;
        x      = px;
        y      = py;
    endtask

    task automatic test_reset;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 12'd0;
        #2 reset = 1'b1;
        #1;
        checks++; if (rgb !== 12'd0) begin errors++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step_pulse); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready); end
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_start;
        enable = 1'b1; mode = 1'b0; video_on = 1'b1;
        pix(5, 5);
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %b expected 1", busy); end
        pix(0, 0);
        tick;
        pix(5, 5);
        tick;
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL start_rgb: got %h expected F00", rgb); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
    endtask

    task automatic test_step;
        int pulses;
        pix(0, 0); #1;
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_first: got %b expected 0", step_pulse); end
        tick; pix(5, 5); tick;
        pix(0, 0); #1;
        checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL step_second: got %b expected 1", step_pulse); end
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_bnd: got %b expected 0", cfg_if.cfg_ready); end
        tick;
        pix(5, 5); #1;
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL step_width: got %b expected 0", step_pulse); end
        tick;
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL step_rgb: got %h expected 0F0", rgb); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pix(0, 0); #1;
            if (step_pulse === 1'b1) pulses++;
            tick; pix(5, 5); tick;
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL step_count: got %0d expected 3", pulses); end
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL idx_wrap: got %h expected F00", rgb); end
    endtask

    task automatic test_bars;
        logic [9:0]  xs  [6];
        logic [11:0] exp [6];
        xs  = '{10'd0, 10'd159, 10'd160, 10'd320, 10'd639, 10'd700};
        exp = '{12'h0F0, 12'h0F0, 12'h00F, 12'hFFF, 12'hF00, 12'hF00};
        for (int i = 0; i < 2; i++) begin
            pix(0, 0); tick; pix(5, 5); tick;
        end
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix(xs[i], 5);
            tick;
            checks++; if (rgb !== exp[i]) begin errors++; $display("FAIL bar_x%0d: got %h expected %h", xs[i], rgb, exp[i]); end
        end
        mode = 1'b0;
        pix(5, 5);
        tick;
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL mode_keeps_idx: got %h expected 0F0", rgb); end
    endtask

    task automatic test_cfg;
        mode = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_data = 12'h123;
        pix(480, 5); #1;
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_mid: got %b expected 1", cfg_if.cfg_ready); end
        tick;
        cfg_if.cfg_valid = 1'b0;
        tick;
        checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL shadow_hidden: got %h expected F00", rgb); end
        pix(0, 0); tick;
        pix(480, 5); tick;
        checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL commit: got %h expected 123", rgb); end
        pix(0, 0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd2; cfg_if.cfg_data = 12'h456;
        #1;
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL held_ready_bnd: got %b expected 0", cfg_if.cfg_ready); end
        tick;
        pix(480, 5); #1;
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL held_ready_next: got %b expected 1", cfg_if.cfg_ready); end
        tick;
        cfg_if.cfg_valid = 1'b0;
        pix(0, 5); tick;
        checks++; if (rgb !== 12'h00F) begin errors++; $display("FAIL held_pending: got %h expected 00F", rgb); end
        pix(0, 0); tick;
        pix(0, 5); tick;
        checks++; if (rgb !== 12'h456) begin errors++; $display("FAIL held_commit: got %h expected 456", rgb); end
    endtask

    task automatic test_video_off;
        video_on = 1'b0;
        tick;
        checks++; if (rgb !== 12'd0) begin errors++; $display("FAIL blank: got %h expected 000", rgb); end
        video_on = 1'b1;
        tick;
        checks++; if (rgb !== 12'h456) begin errors++; $display("FAIL unblank: got %h expected 456", rgb); end
        enable = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b expected 0", busy); end
        checks++; if (rgb !== 12'h456) begin errors++; $display("FAIL disable_lag: got %h expected 456", rgb); end
        tick;
        checks++; if (rgb !== 12'd0) begin errors++; $display("FAIL disable_rgb: got %h expected 000", rgb); end
    endtask

    task automatic test_reset_mid;
        logic [9:0]  xs  [4];
        logic [11:0] exp [4];
        xs  = '{10'd0, 10'd160, 10'd320, 10'd480};
        exp = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        enable = 1'b1;
        pix(0, 5); tick;
        pix(0, 0); tick;
        pix(0, 5);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_data = 12'hABC;
        tick;
        cfg_if.cfg_valid = 1'b0;
        tick;
        checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL pre_reset_rgb: got %h expected 123", rgb); end
        reset = 1'b1;
        #1;
        checks++; if (rgb !== 12'd0) begin errors++; $display("FAIL midreset_rgb: got %h expected 000", rgb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL midreset_step: got %b expected 0", step_pulse); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", cfg_if.cfg_ready); end
        tick;
        reset = 1'b0;
        mode = 1'b1;
        tick;
        pix(0, 0); tick;
        for (int i = 0; i < 4; i++) begin
            pix(xs[i], 5);
            tick;
            checks++; if (rgb !== exp[i]) begin errors++; $display("FAIL default_pal_x%0d: got %h expected %h", xs[i], rgb, exp[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_step;
        test_bars;
        test_cfg;
        test_video_off;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
